// File: rtl/matmul_tile_scheduler.sv
// Tile-loop sequencer for the 8x8 matrix multiplication engine: walks an M x N x K tile grid,
// generating A/B/C BRAM addresses and the start / clear_done / PE-reset handshakes.
module matmul_tile_scheduler #(
    parameter int unsigned AWIDTH = 11,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     num_tiles_m_i,
    input  logic [CNT_W-1:0]     num_tiles_n_i,
    input  logic [CNT_W-1:0]     num_tiles_k_i,
    input  logic [AWIDTH-1:0]    base_a_i,
    input  logic [AWIDTH-1:0]    base_b_i,
    input  logic [AWIDTH-1:0]    base_c_i,
    input  logic [AWIDTH-1:0]    tile_stride_a_i,
    input  logic [AWIDTH-1:0]    tile_stride_b_i,
    input  logic [AWIDTH-1:0]    tile_stride_c_i,
    input  logic                 mm_done_i,
    output logic                 mm_start_reg_o,
    output logic                 mm_clear_done_reg_o,
    output logic                 mm_pe_resetn_o,
    output logic [AWIDTH-1:0]    mm_address_mat_a_o,
    output logic [AWIDTH-1:0]    mm_address_mat_b_o,
    output logic [AWIDTH-1:0]    mm_address_mat_c_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [3*CNT_W-1:0]   tiles_issued_o
);
    localparam int unsigned TILE_W = 3 * CNT_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PE_RST = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_CLEAR  = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_m_q, cnt_m_d, cnt_n_q, cnt_n_d, cnt_k_q, cnt_k_d;
    logic [CNT_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
    logic [AWIDTH-1:0] stride_a_q, stride_a_d, stride_b_q, stride_b_d, stride_c_q, stride_c_d;
    logic [AWIDTH-1:0] stride_bk_q, stride_bk_d, base_b_q, base_b_d;
    logic [AWIDTH-1:0] a_ptr_q, a_ptr_d, a_row_q, a_row_d;
    logic [AWIDTH-1:0] b_ptr_q, b_ptr_d, b_col_q, b_col_d;
    logic [AWIDTH-1:0] c_ptr_q, c_ptr_d;
    logic [AWIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_c_q, addr_c_d;
    logic              start_reg_q, start_reg_d, clear_q, clear_d, pe_resetn_q, pe_resetn_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [TILE_W-1:0] tiles_q, tiles_d;

    logic [CNT_W-1:0]  m_eff_c, n_eff_c, k_eff_c;
    logic [AWIDTH-1:0] stride_bk_c;
    logic              k_last_c, n_last_c, m_last_c;

    assign m_eff_c = (num_tiles_m_i == '0) ? CNT_W'(1) : num_tiles_m_i;
    assign n_eff_c = (num_tiles_n_i == '0) ? CNT_W'(1) : num_tiles_n_i;
    assign k_eff_c = (num_tiles_k_i == '0) ? CNT_W'(1) : num_tiles_k_i;

    assign k_last_c = (k_q == cnt_k_q - CNT_W'(1));
    assign n_last_c = (n_q == cnt_n_q - CNT_W'(1));
    assign m_last_c = (m_q == cnt_m_q - CNT_W'(1));

    // B advances by N tiles per k step; N*stride_b is formed once at start by shift-add.
    always_comb begin
        stride_bk_c = '0;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            if (n_eff_c[i]) begin
                stride_bk_c = stride_bk_c + (tile_stride_b_i << i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_m_d     = cnt_m_q;
        cnt_n_d     = cnt_n_q;
        cnt_k_d     = cnt_k_q;
        m_d         = m_q;
        n_d         = n_q;
        k_d         = k_q;
        stride_a_d  = stride_a_q;
        stride_b_d  = stride_b_q;
        stride_c_d  = stride_c_q;
        stride_bk_d = stride_bk_q;
        base_b_d    = base_b_q;
        a_ptr_d     = a_ptr_q;
        a_row_d     = a_row_q;
        b_ptr_d     = b_ptr_q;
        b_col_d     = b_col_q;
        c_ptr_d     = c_ptr_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        addr_c_d    = addr_c_q;
        tiles_d     = tiles_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_m_d     = m_eff_c;
                    cnt_n_d     = n_eff_c;
                    cnt_k_d     = k_eff_c;
                    m_d         = '0;
                    n_d         = '0;
                    k_d         = '0;
                    stride_a_d  = tile_stride_a_i;
                    stride_b_d  = tile_stride_b_i;
                    stride_c_d  = tile_stride_c_i;
                    stride_bk_d = stride_bk_c;
                    base_b_d    = base_b_i;
                    a_ptr_d     = base_a_i;
                    a_row_d     = base_a_i;
                    b_ptr_d     = base_b_i;
                    b_col_d     = base_b_i;
                    c_ptr_d     = base_c_i;
                    tiles_d     = '0;
                    state_d     = S_PE_RST;
                end
            end
            S_PE_RST: state_d = S_ISSUE;
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT: begin
                if (mm_done_i) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = S_NEXT;
            // k innermost: A steps by one tile, B by a full row of N tiles
            S_NEXT: begin
                if (!k_last_c) begin
                    k_d     = k_q + CNT_W'(1);
                    a_ptr_d = a_ptr_q + stride_a_q;
                    b_ptr_d = b_ptr_q + stride_bk_q;
                    state_d = S_ISSUE;
                end else if (!n_last_c) begin
                    k_d     = '0;
                    n_d     = n_q + CNT_W'(1);
                    a_ptr_d = a_row_q;
                    b_col_d = b_col_q + stride_b_q;
                    b_ptr_d = b_col_q + stride_b_q;
                    c_ptr_d = c_ptr_q + stride_c_q;
                    state_d = S_PE_RST;
                end else if (!m_last_c) begin
                    k_d     = '0;
                    n_d     = '0;
                    m_d     = m_q + CNT_W'(1);
                    a_row_d = a_ptr_q + stride_a_q;
                    a_ptr_d = a_ptr_q + stride_a_q;
                    b_col_d = base_b_q;
                    b_ptr_d = base_b_q;
                    c_ptr_d = c_ptr_q + stride_c_q;
                    state_d = S_PE_RST;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // Handshake outputs are registered from the state being entered.
        start_reg_d = (state_d == S_ISSUE);
        clear_d     = (state_d == S_CLEAR);
        pe_resetn_d = (state_d != S_PE_RST);
        done_d      = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        if (state_d == S_ISSUE) begin
            addr_a_d = a_ptr_d;
            addr_b_d = b_ptr_d;
            addr_c_d = c_ptr_d;
            tiles_d  = tiles_q + TILE_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_m_q     <= '0;
            cnt_n_q     <= '0;
            cnt_k_q     <= '0;
            m_q         <= '0;
            n_q         <= '0;
            k_q         <= '0;
            stride_a_q  <= '0;
            stride_b_q  <= '0;
            stride_c_q  <= '0;
            stride_bk_q <= '0;
            base_b_q    <= '0;
            a_ptr_q     <= '0;
            a_row_q     <= '0;
            b_ptr_q     <= '0;
            b_col_q     <= '0;
            c_ptr_q     <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            addr_c_q    <= '0;
            start_reg_q <= 1'b0;
            clear_q     <= 1'b0;
            pe_resetn_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tiles_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_m_q     <= cnt_m_d;
            cnt_n_q     <= cnt_n_d;
            cnt_k_q     <= cnt_k_d;
            m_q         <= m_d;
            n_q         <= n_d;
            k_q         <= k_d;
            stride_a_q  <= stride_a_d;
            stride_b_q  <= stride_b_d;
            stride_c_q  <= stride_c_d;
            stride_bk_q <= stride_bk_d;
            base_b_q    <= base_b_d;
            a_ptr_q     <= a_ptr_d;
            a_row_q     <= a_row_d;
            b_ptr_q     <= b_ptr_d;
            b_col_q     <= b_col_d;
            c_ptr_q     <= c_ptr_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            addr_c_q    <= addr_c_d;
            start_reg_q <= start_reg_d;
            clear_q     <= clear_d;
            pe_resetn_q <= pe_resetn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tiles_q     <= tiles_d;
        end
    end

    assign mm_start_reg_o      = start_reg_q;
    assign mm_clear_done_reg_o = clear_q;
    assign mm_pe_resetn_o      = pe_resetn_q;
    assign mm_address_mat_a_o  = addr_a_q;
    assign mm_address_mat_b_o  = addr_b_q;
    assign mm_address_mat_c_o  = addr_c_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
    assign tiles_issued_o      = tiles_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Bench for matmul_tile_scheduler: engine responder, event monitor and a nested-loop address model.
module tb_matmul_tile_scheduler;
    localparam int unsigned AW = 11;
    localparam int unsigned CW = 4;

    logic            clk;
    logic            reset;
    logic            start;
    logic [CW-1:0]   num_m, num_n, num_k;
    logic [AW-1:0]   base_a, base_b, base_c, str_a, str_b, str_c;
    logic            mm_done;
    logic            mm_start_reg, mm_clear_done_reg, mm_pe_resetn;
    logic [AW-1:0]   addr_a, addr_b, addr_c;
    logic            busy, done;
    logic [3*CW-1:0] tiles_issued;

    matmul_tile_scheduler #(.AWIDTH(AW), .CNT_W(CW)) dut (
        .clk_i               (clk),
        .reset_i             (reset),
        .start_i             (start),
        .num_tiles_m_i       (num_m),
        .num_tiles_n_i       (num_n),
        .num_tiles_k_i       (num_k),
        .base_a_i            (base_a),
        .base_b_i            (base_b),
        .base_c_i            (base_c),
        .tile_stride_a_i     (str_a),
        .tile_stride_b_i     (str_b),
        .tile_stride_c_i     (str_c),
        .mm_done_i           (mm_done),
        .mm_start_reg_o      (mm_start_reg),
        .mm_clear_done_reg_o (mm_clear_done_reg),
        .mm_pe_resetn_o      (mm_pe_resetn),
        .mm_address_mat_a_o  (addr_a),
        .mm_address_mat_b_o  (addr_b),
        .mm_address_mat_c_o  (addr_c),
        .busy_o              (busy),
        .done_o              (done),
        .tiles_issued_o      (tiles_issued)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Monitor log of each engine start, plus handshake counters
    logic [AW-1:0] q_a[$], q_b[$], q_c[$];
    bit            q_pe[$], q_clr[$];
    int            pe_cnt, done_cnt, ncyc, rise_cyc, done_cyc;
    bit            pe_flag, clr_flag, prev_mm_done;
    bit            engine_hold;
    bit            pending;
    int            dly;

    int cfg_m, cfg_n, cfg_k, cfg_ba, cfg_bb, cfg_bc, cfg_sa, cfg_sb, cfg_sc;

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    initial begin
        pe_cnt = 0; done_cnt = 0; ncyc = 0; rise_cyc = 0; done_cyc = 0;
        pe_flag = 0; clr_flag = 0; prev_mm_done = 0;
        forever begin
            @(negedge clk);
            if (mm_pe_resetn === 1'b0) begin
                pe_cnt++;
                pe_flag = 1;
            end
            if (mm_clear_done_reg === 1'b1) clr_flag = 1;
            if (mm_start_reg === 1'b1) begin
                q_a.push_back(addr_a);
                q_b.push_back(addr_b);
                q_c.push_back(addr_c);
                q_pe.push_back(pe_flag);
                q_clr.push_back(clr_flag);
                pe_flag = 0;
                clr_flag = 0;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = ncyc;
            end
            if (mm_done && !prev_mm_done) rise_cyc = ncyc;
            prev_mm_done = mm_done;
            ncyc++;
        end
    end

    // Engine model: done rises a random delay after start, held until clear_done
    initial begin
        mm_done = 1'b0;
        pending = 0;
        dly = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                pending = 0;
                mm_done = 1'b0;
            end else begin
                if (mm_clear_done_reg) mm_done = 1'b0;
                if (mm_start_reg) begin
                    pending = 1;
                    dly = int'($urandom_range(0, 3));
                end else if (pending && !engine_hold) begin
                    if (dly == 0) begin
                        mm_done = 1'b1;
                        pending = 0;
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        q_a.delete(); q_b.delete(); q_c.delete(); q_pe.delete(); q_clr.delete();
        pe_cnt = 0; done_cnt = 0; pe_flag = 0; clr_flag = 0;
    endtask

    task automatic start_job(input int m, n, k, ba, bb, bc, sa, sb, sc);
        @(posedge clk); #1;
        clear_log();
        cfg_m = m; cfg_n = n; cfg_k = k;
        cfg_ba = ba; cfg_bb = bb; cfg_bc = bc;
        cfg_sa = sa; cfg_sb = sb; cfg_sc = sc;
        num_m = CW'(m); num_n = CW'(n); num_k = CW'(k);
        base_a = AW'(ba); base_b = AW'(bb); base_c = AW'(bc);
        str_a = AW'(sa); str_b = AW'(sb); str_c = AW'(sc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
        // Config must have been latched; scramble the inputs while busy
        num_m = CW'($urandom); num_n = CW'($urandom); num_k = CW'($urandom);
        base_a = AW'($urandom); base_b = AW'($urandom); base_c = AW'($urandom);
        str_a = AW'($urandom); str_b = AW'($urandom); str_c = AW'($urandom);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (done !== 1'b1 && c < 5000) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_timeout: got done=%b expected 1 within 5000 cycles", name, done);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL %s idle_after_done: got busy=%b done=%b expected 0 0", name, busy, done);
        end
    endtask

    // Compare the logged run against the nested-loop address formulas
    task automatic verify_run(input string name);
        int m, n, k, idx;
        logic [AW-1:0] ea, eb, ec;
        bit pe_e, clr_e;
        m = eff(cfg_m); n = eff(cfg_n); k = eff(cfg_k);
        idx = 0;
        ea = '0; eb = '0; ec = '0;
        checks++;
        if (q_a.size() != m * n * k) begin
            failures++;
            $display("FAIL %s start_count: got %0d expected %0d", name, q_a.size(), m * n * k);
        end
        for (int mi = 0; mi < m; mi++) begin
            for (int ni = 0; ni < n; ni++) begin
                for (int ki = 0; ki < k; ki++) begin
                    ea = AW'(cfg_ba + (mi * k + ki) * cfg_sa);
                    eb = AW'(cfg_bb + (ki * n + ni) * cfg_sb);
                    ec = AW'(cfg_bc + (mi * n + ni) * cfg_sc);
                    pe_e = (ki == 0);
                    clr_e = (idx != 0);
                    if (idx < q_a.size()) begin
                        checks++;
                        if ({q_a[idx], q_b[idx], q_c[idx]} !== {ea, eb, ec}) begin
                            failures++;
                            $display("FAIL %s addr[%0d]: got A=%h B=%h C=%h expected A=%h B=%h C=%h",
                                     name, idx, q_a[idx], q_b[idx], q_c[idx], ea, eb, ec);
                        end
                        checks++;
                        if ({q_pe[idx], q_clr[idx]} !== {pe_e, clr_e}) begin
                            failures++;
                            $display("FAIL %s handshake_order[%0d]: got pe_rst=%b clear=%b expected %b %b",
                                     name, idx, q_pe[idx], q_clr[idx], pe_e, clr_e);
                        end
                    end
                    idx++;
                end
            end
        end
        checks++;
        if (pe_cnt != m * n) begin
            failures++;
            $display("FAIL %s pe_resetn_cycles: got %0d expected %0d", name, pe_cnt, m * n);
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
        end
        checks++;
        if (tiles_issued !== 12'(m * n * k)) begin
            failures++;
            $display("FAIL %s tiles_issued: got %0d expected %0d", name, tiles_issued, m * n * k);
        end
        checks++;
        if ({addr_a, addr_b, addr_c} !== {ea, eb, ec}) begin
            failures++;
            $display("FAIL %s addr_hold_idle: got A=%h B=%h C=%h expected A=%h B=%h C=%h",
                     name, addr_a, addr_b, addr_c, ea, eb, ec);
        end
    endtask

    task automatic wait_first_issue(input string name);
        int c = 0;
        while (q_a.size() == 0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (q_a.size() == 0) begin
            failures++;
            $display("FAIL %s first_issue_timeout: got 0 starts expected 1 within 100 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mm_start_reg, mm_clear_done_reg, mm_pe_resetn, busy, done} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_ctrl: got start=%b clear=%b pe_resetn=%b busy=%b done=%b expected 0 0 1 0 0",
                     mm_start_reg, mm_clear_done_reg, mm_pe_resetn, busy, done);
        end
        checks++;
        if ({addr_a, addr_b, addr_c} !== 33'd0) begin
            failures++;
            $display("FAIL reset_addr: got A=%h B=%h C=%h expected 0", addr_a, addr_b, addr_c);
        end
        checks++;
        if (tiles_issued !== 12'd0) begin
            failures++;
            $display("FAIL reset_tiles: got %0d expected 0", tiles_issued);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_tile();
        start_job(1, 1, 1, 'h000, 'h100, 'h200, 8, 8, 8);
        wait_done("single");
        verify_run("single");
        checks++;
        if (done_cyc - rise_cyc != 3) begin
            failures++;
            $display("FAIL single done_latency: got %0d expected 3", done_cyc - rise_cyc);
        end
    endtask

    task automatic test_grid_2x2x2();
        start_job(2, 2, 2, 'h000, 'h100, 'h200, 8, 8, 8);
        wait_done("grid222");
        verify_run("grid222");
    endtask

    task automatic test_k_accumulate();
        start_job(1, 1, 3, 'h040, 'h080, 'h0c0, 16, 32, 4);
        wait_done("k3");
        verify_run("k3");
    endtask

    task automatic test_start_ignored();
        int c = 0;
        engine_hold = 1;
        start_job(1, 1, 1, 'h010, 'h020, 'h030, 1, 1, 1);
        wait_first_issue("ignore");
        repeat (2) begin @(posedge clk); #1; end
        num_m = 4'd2; num_n = 4'd2; num_k = 4'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        engine_hold = 0;
        while (done !== 1'b1 && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore busy_after: got %b expected 0", busy);
        end
        verify_run("ignore");
    endtask

    task automatic test_reset_in_wait();
        engine_hold = 1;
        start_job(2, 2, 2, 'h100, 'h200, 'h300, 4, 4, 4);
        wait_first_issue("rst_wait");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mm_start_reg, mm_clear_done_reg, mm_pe_resetn, busy, done} !== 5'b00100) begin
            failures++;
            $display("FAIL rst_wait ctrl: got start=%b clear=%b pe_resetn=%b busy=%b done=%b expected 0 0 1 0 0",
                     mm_start_reg, mm_clear_done_reg, mm_pe_resetn, busy, done);
        end
        checks++;
        if ({addr_a, addr_b, addr_c} !== 33'd0 || tiles_issued !== 12'd0) begin
            failures++;
            $display("FAIL rst_wait addr_tiles: got A=%h B=%h C=%h tiles=%0d expected 0",
                     addr_a, addr_b, addr_c, tiles_issued);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        engine_hold = 0;
        start_job(2, 1, 2, 'h004, 'h104, 'h204, 12, 20, 28);
        wait_done("after_rst");
        verify_run("after_rst");
    endtask

    task automatic test_addr_wrap();
        start_job(0, 0, 2, 'h7F8, 'h010, 'h020, 8, 8, 8);
        wait_done("wrap");
        verify_run("wrap");
        checks++;
        if (q_a.size() < 2 || q_a[1] !== 11'h000) begin
            failures++;
            $display("FAIL wrap a_second: got %h expected 000", (q_a.size() < 2) ? 11'h7ff : q_a[1]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            start_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                      int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)),
                      int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
            wait_done("random");
            verify_run("random");
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        engine_hold = 0;
        num_m = '0; num_n = '0; num_k = '0;
        base_a = '0; base_b = '0; base_c = '0;
        str_a = '0; str_b = '0; str_c = '0;
        test_reset();
        test_single_tile();
        test_grid_2x2x2();
        test_k_accumulate();
        test_start_ignored();
        test_reset_in_wait();
        test_addr_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
